gray_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for one shared 3-bit Gray-code counter. A requester asks for a number of counter steps. The arbiter grants the counter to one requester at a time, clears it, drives its enable for exactly that many cycles, then returns the final Gray value and the counter's wrap flag. It sits between the two client blocks and the counter: it owns the counter's `En` and `Reset` inputs and reads its `Output` and `Overflow`.

---
 rtl/gray_arbiter.sv | 145 ++++++++++++++
 tb/tb_gray_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_arbiter
// Description : Two-requester round-robin arbiter and sequencer for a shared
//               3-bit Gray-code counter. The owner's counter is cleared, then
//               stepped the requested number of times, and the final Gray
//               value and wrap flag are returned with a one-cycle Done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_arbiter #(
    parameter int STEP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic [STEP_W-1:0] StepsA,
    input  logic [STEP_W-1:0] StepsB,
    output logic              GntA,
    output logic              GntB,
    output logic              DoneA,
    output logic              DoneB,
    output logic [2:0]        Result,
    output logic              Wrapped,
    output logic              Busy,
    output logic              CntEn,
    output logic              CntReset,
    input  logic [2:0]        CntOutput,
    input  logic              CntOverflow
);

    // Sequencer states
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Requester identifiers used for the round-robin history bit
    localparam logic c_SEL_A = 1'b0;
    localparam logic c_SEL_B = 1'b1;

    localparam logic [STEP_W-1:0] c_REM_ZERO = '0;
    localparam logic [STEP_W-1:0] c_REM_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state_q,   w_state_d;
    logic [STEP_W-1:0] r_rem_q,     w_rem_d;
    logic              r_last_q,    w_last_d;
    logic              r_gnt_a_q,   w_gnt_a_d;
    logic              r_gnt_b_q,   w_gnt_b_d;
    logic              r_done_a_q,  w_done_a_d;
    logic              r_done_b_q,  w_done_b_d;
    logic [2:0]        r_result_q,  w_result_d;
    logic              r_wrapped_q, w_wrapped_d;

    // B wins when it is alone, or on a tie when A was the last owner
    logic w_pick_b;
    assign w_pick_b = ReqB & (~ReqA | (r_last_q == c_SEL_A));

    // Next-state and next-output computation for the grant sequencer
    always_comb begin
        w_state_d   = r_state_q;
        w_rem_d     = r_rem_q;
        w_last_d    = r_last_q;
        w_gnt_a_d   = r_gnt_a_q;
        w_gnt_b_d   = r_gnt_b_q;
        w_done_a_d  = 1'b0;
        w_done_b_d  = 1'b0;
        w_result_d  = r_result_q;
        w_wrapped_d = r_wrapped_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (ReqA | ReqB) begin
                    w_state_d = c_ST_CLEAR;
                    w_last_d  = w_pick_b ? c_SEL_B : c_SEL_A;
                    w_rem_d   = w_pick_b ? StepsB : StepsA;
                    w_gnt_a_d = ~w_pick_b;
                    w_gnt_b_d = w_pick_b;
                end
            end
            c_ST_CLEAR: begin
                // A zero-step request skips RUN entirely
                w_state_d = (r_rem_q != c_REM_ZERO) ? c_ST_RUN : c_ST_DONE;
            end
            c_ST_RUN: begin
                w_rem_d = r_rem_q - c_REM_ONE;
                if (r_rem_q == c_REM_ONE) begin
                    w_state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                // Counter has absorbed the last enable edge; capture it now
                w_result_d  = CntOutput;
                w_wrapped_d = CntOverflow;
                w_done_a_d  = r_gnt_a_q;
                w_done_b_d  = r_gnt_b_q;
                w_gnt_a_d   = 1'b0;
                w_gnt_b_d   = 1'b0;
                w_state_d   = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset cancels any in-flight Done
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_q   <= c_ST_IDLE;
            r_rem_q     <= c_REM_ZERO;
            r_last_q    <= c_SEL_B;
            r_gnt_a_q   <= 1'b0;
            r_gnt_b_q   <= 1'b0;
            r_done_a_q  <= 1'b0;
            r_done_b_q  <= 1'b0;
            r_result_q  <= 3'b000;
            r_wrapped_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_rem_q     <= w_rem_d;
            r_last_q    <= w_last_d;
            r_gnt_a_q   <= w_gnt_a_d;
            r_gnt_b_q   <= w_gnt_b_d;
            r_done_a_q  <= w_done_a_d;
            r_done_b_q  <= w_done_b_d;
            r_result_q  <= w_result_d;
            r_wrapped_q <= w_wrapped_d;
        end
    end

    assign GntA    = r_gnt_a_q;
    assign GntB    = r_gnt_b_q;
    assign DoneA   = r_done_a_q;
    assign DoneB   = r_done_b_q;
    assign Result  = r_result_q;
    assign Wrapped = r_wrapped_q;
    assign Busy    = r_gnt_a_q | r_gnt_b_q;

    // Counter controls are combinational so system reset also clears the counter
    assign CntReset = Reset | (r_state_q == c_ST_CLEAR);
    assign CntEn    = (r_state_q == c_ST_RUN) & ~Reset;

endmodule
`default_nettype wire

// File: tb/tb_gray_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_arbiter
// Description : Scoreboard bench for gray_arbiter with a behavioural Gray
//               counter attached to the counter-side ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_arbiter;

    localparam int STEP_W = 4;

    logic              clk;
    logic              Reset;
    logic              ReqA, ReqB;
    logic [STEP_W-1:0] StepsA, StepsB;
    logic              GntA, GntB, DoneA, DoneB;
    logic [2:0]        Result;
    logic              Wrapped, Busy, CntEn, CntReset;
    logic [2:0]        CntOutput;
    logic              CntOverflow;

    gray_arbiter #(.STEP_W(STEP_W)) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .ReqA        (ReqA),
        .ReqB        (ReqB),
        .StepsA      (StepsA),
        .StepsB      (StepsB),
        .GntA        (GntA),
        .GntB        (GntB),
        .DoneA       (DoneA),
        .DoneB       (DoneB),
        .Result      (Result),
        .Wrapped     (Wrapped),
        .Busy        (Busy),
        .CntEn       (CntEn),
        .CntReset    (CntReset),
        .CntOutput   (CntOutput),
        .CntOverflow (CntOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared counter: binary index, Gray output, sticky overflow on 4->0
    logic [2:0] cnt_idx;
    always @(posedge clk) begin
        if (CntReset) begin
            cnt_idx     <= 3'd0;
            CntOverflow <= 1'b0;
        end else if (CntEn) begin
            if (cnt_idx == 3'd7) CntOverflow <= 1'b1;
            cnt_idx <= cnt_idx + 3'd1;
        end
    end
    assign CntOutput = cnt_idx ^ (cnt_idx >> 1);

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct packed {
        logic       is_b;
        logic [2:0] res;
        logic       wr;
    } exp_t;
    exp_t sb[$];

    // Monitor: every Done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!Reset && (DoneA || DoneB)) begin
            chk("done_onehot", {31'd0, DoneA & DoneB}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_owner", {31'd0, DoneB}, {31'd0, e.is_b});
                chk("result",     {29'd0, Result}, {29'd0, e.res});
                chk("wrapped",    {31'd0, Wrapped}, {31'd0, e.wr});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
    endtask

    // Single request: checks grant length, enable count and Done latency
    task automatic run_req(input bit is_b, input int steps, input logic [2:0] er,
                           input logic ew, input int drop_k);
        int gnt_n, en_n, both_n, done_k;
        sb.push_back('{is_b: is_b, res: er, wr: ew});
        @(posedge clk); #1;
        if (is_b) begin ReqB = 1'b1; StepsB = steps[STEP_W-1:0]; end
        else      begin ReqA = 1'b1; StepsA = steps[STEP_W-1:0]; end
        gnt_n = 0; en_n = 0; both_n = 0; done_k = -1;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (k == drop_k) begin
                // Withdraw the request and change Steps mid-grant; both must be ignored
                ReqA = 1'b0; ReqB = 1'b0; StepsA = 4'd1; StepsB = 4'd1;
            end
            if (is_b ? GntB : GntA) gnt_n++;
            if (GntA && GntB) both_n++;
            if (CntEn) en_n++;
            if (is_b ? DoneB : DoneA) begin
                done_k = k;
                ReqA = 1'b0; ReqB = 1'b0;
            end
        end
        chk("gnt_cycles", gnt_n, steps + 2);
        chk("en_cycles",  en_n,  steps);
        chk("done_at",    done_k, steps + 3);
        chk("gnt_onehot", both_n, 0);
        @(negedge clk);
        chk("busy_after", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int done_n, gnt_a_n, gnt_b_n, stray;
        int done_ks[4];
        Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0; StepsA = '0; StepsB = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnta",    {31'd0, GntA}, 32'd0);
        chk("rst_gntb",    {31'd0, GntB}, 32'd0);
        chk("rst_done",    {30'd0, DoneA, DoneB}, 32'd0);
        chk("rst_busy",    {31'd0, Busy}, 32'd0);
        chk("rst_cnten",   {31'd0, CntEn}, 32'd0);
        chk("rst_cntrst",  {31'd0, CntReset}, 32'd1);
        chk("rst_result",  {29'd0, Result}, 32'd0);
        chk("rst_wrapped", {31'd0, Wrapped}, 32'd0);
        @(posedge clk); #1 Reset = 1'b0;

        run_req(1'b0, 3,  3'b010, 1'b0, -1);
        run_req(1'b0, 8,  3'b000, 1'b1, -1);
        run_req(1'b0, 15, 3'b100, 1'b1, -1);

        // Reset during RUN of a 10-step request
        @(posedge clk); #1;
        ReqA = 1'b1; StepsA = 4'd10;
        repeat (5) @(negedge clk);
        chk("mid_cnten_before", {31'd0, CntEn}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("mid_cntrst_async", {31'd0, CntReset}, 32'd1);
        chk("mid_cnten_masked", {31'd0, CntEn}, 32'd0);
        @(negedge clk);
        chk("mid_busy",    {31'd0, Busy}, 32'd0);
        chk("mid_cnten",   {31'd0, CntEn}, 32'd0);
        chk("mid_cntrst",  {31'd0, CntReset}, 32'd1);
        chk("mid_result",  {29'd0, Result}, 32'd0);
        chk("mid_wrapped", {31'd0, Wrapped}, 32'd0);
        Reset = 1'b0; ReqA = 1'b0;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (DoneA || DoneB) stray++;
        end
        chk("mid_no_done", stray, 0);

        run_req(1'b0, 3, 3'b010, 1'b0, -1);
        run_req(1'b1, 0, 3'b000, 1'b0, -1);
        run_req(1'b0, 5, 3'b111, 1'b0, 2);

        // Tie with both requests held: A first after reset, then alternate
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back('{is_b: (i % 2 == 1), res: 3'b011, wr: 1'b0});
        @(posedge clk); #1;
        ReqA = 1'b1; ReqB = 1'b1; StepsA = 4'd2; StepsB = 4'd2;
        done_n = 0; gnt_a_n = 0; gnt_b_n = 0;
        for (int i = 0; i < 4; i++) done_ks[i] = -1;
        for (int k = 0; k < 60 && done_n < 4; k++) begin
            @(negedge clk);
            if (GntA) gnt_a_n++;
            if (GntB) gnt_b_n++;
            if (DoneA || DoneB) begin
                done_ks[done_n] = k;
                done_n++;
                if (done_n == 4) begin ReqA = 1'b0; ReqB = 1'b0; end
            end
        end
        chk("tie_done_count", done_n, 4);
        chk("tie_gnta_cycles", gnt_a_n, 8);
        chk("tie_gntb_cycles", gnt_b_n, 8);
        for (int i = 0; i < 4; i++) chk("tie_done_at", done_ks[i], 5 * (i + 1));
        repeat (3) @(negedge clk);
        chk("tie_idle", {31'd0, Busy}, 32'd0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
